fetch_ctrl_fsm: RTL and testbench

Multicycle fetch/sequencing controller that sits directly upstream of the instruction decoder. Fetches the instruction at the current PC from RAM port B and holds it in an instruction register, which drives the decoder's instr_set input. Enables the decoder and adds an extra memory phase for LOAD/STOR. Emits a one-cycle commit strobe that gates the register-file write and the PC update.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_ctrl_fsm_if.sv | 25 ++
 rtl/fetch_ctrl_fsm.sv | 107 ++++++++++
 tb/tb_fetch_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch FSM states and
// the LOAD/STOR opcode fields also used by the decoder.
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_COMMIT = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDST  = 4'b0100;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  function automatic logic is_ldst(
    input logic [3:0] op,
    input logic [3:0] ext
  );
    return (op == OP_LDST) &&
           ((ext == EXT_LOAD) || (ext == EXT_STOR));
  endfunction

endpackage

// File: rtl/fetch_ctrl_fsm_if.sv
// RAM port-B read bus between the fetch controller
// (master) and the instruction RAM (slave).
interface fetch_ctrl_fsm_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic [DATA_W-1:0] ram_addr_b;
  logic              ram_en_b;
  logic [DATA_W-1:0] ram_q_b;

  modport master (
    output ram_addr_b,
    output ram_en_b,
    input  ram_q_b
  );

  modport slave (
    input  ram_addr_b,
    input  ram_en_b,
    output ram_q_b
  );

endinterface

// File: rtl/fetch_ctrl_fsm.sv
// Multicycle fetch/sequencing controller feeding
// the decoder; one commit strobe per instruction.
module fetch_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] pc,
  fetch_ctrl_fsm_if.master  ram,
  output logic [DATA_W-1:0] instr_set,
  output logic              decoder_en,
  output logic              mem_phase,
  output logic              is_mem,
  output logic              commit,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_count,
  output logic [2:0]        state_o
);

  state_t            state;
  state_t            state_n;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] addr_q;
  logic              capture;

  assign capture = (state == S_FWAIT) &&
                   (wait_cnt == 2'd0);
  assign busy    = (state != S_IDLE);
  assign state_o = state;

  // State, fetch address, IR and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      instr_set   <= '0;
      is_mem      <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_FETCH) begin
        wait_cnt <= 2'(RAM_LAT - 1);
        addr_q   <= pc;
      end
      if (state == S_FWAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
      if (capture) begin
        instr_set <= ram.ram_q_b;
        is_mem    <= is_ldst(ram.ram_q_b[15:12],
                             ram.ram_q_b[7:4]);
      end
      if (state == S_COMMIT)
        instr_count <= instr_count + 1'b1;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_n        = state;
    ram.ram_en_b   = 1'b0;
    ram.ram_addr_b = '0;
    decoder_en     = 1'b0;
    mem_phase      = 1'b0;
    commit         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_n = S_FETCH;
      end
      S_FETCH: begin
        ram.ram_en_b   = 1'b1;
        ram.ram_addr_b = pc;
        state_n        = S_FWAIT;
      end
      S_FWAIT: begin
        ram.ram_en_b   = 1'b1;
        ram.ram_addr_b = addr_q;
        if (wait_cnt == 2'd0) state_n = S_DECODE;
      end
      S_DECODE: begin
        decoder_en = 1'b1;
        state_n    = S_EXEC;
      end
      S_EXEC: begin
        decoder_en = 1'b1;
        state_n    = is_mem ? S_MEM : S_COMMIT;
      end
      S_MEM: begin
        decoder_en = 1'b1;
        mem_phase  = 1'b1;
        state_n    = S_COMMIT;
      end
      S_COMMIT: begin
        decoder_en = 1'b1;
        commit     = 1'b1;
        state_n    = run ? S_FETCH : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl_fsm.sv
// Bench: table of instructions through a
// scoreboard, plus stop/reset/latency/wrap cases.
module tb_fetch_ctrl_fsm;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 1: RAM_LAT=1, CNT_W=4
  logic        reset, run;
  logic [15:0] pc;
  logic [15:0] instr_set;
  logic        decoder_en, mem_phase, is_mem;
  logic        commit, busy;
  logic [3:0]  instr_count;
  logic [2:0]  state_o;

  fetch_ctrl_fsm_if #(.DATA_W(16)) bus1 ();

  fetch_ctrl_fsm #(
    .DATA_W(16), .RAM_LAT(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .reset(reset), .run(run),
    .pc(pc), .ram(bus1),
    .instr_set(instr_set),
    .decoder_en(decoder_en),
    .mem_phase(mem_phase), .is_mem(is_mem),
    .commit(commit), .busy(busy),
    .instr_count(instr_count),
    .state_o(state_o)
  );

  logic [15:0] rom_word, exp_addr, a1;
  always @(posedge clk)
    if (bus1.ram_en_b) a1 <= bus1.ram_addr_b;
  assign bus1.ram_q_b =
    (a1 == exp_addr) ? rom_word : 16'hDEAD;

  // DUT 2: RAM_LAT=2, CNT_W=16
  logic        reset2, run2;
  logic [15:0] pc2;
  logic [15:0] instr_set2;
  logic        decoder_en2, mem_phase2, is_mem2;
  logic        commit2, busy2;
  logic [15:0] instr_count2;
  logic [2:0]  state2;

  fetch_ctrl_fsm_if #(.DATA_W(16)) bus2 ();

  fetch_ctrl_fsm #(
    .DATA_W(16), .RAM_LAT(2), .CNT_W(16)
  ) dut2 (
    .clk(clk), .reset(reset2), .run(run2),
    .pc(pc2), .ram(bus2),
    .instr_set(instr_set2),
    .decoder_en(decoder_en2),
    .mem_phase(mem_phase2), .is_mem(is_mem2),
    .commit(commit2), .busy(busy2),
    .instr_count(instr_count2),
    .state_o(state2)
  );

  logic [15:0] p2a, p2b;
  always @(posedge clk)
    if (bus2.ram_en_b) begin
      p2a <= bus2.ram_addr_b;
      p2b <= p2a;
    end
  assign bus2.ram_q_b =
    (p2b == 16'h0010) ? 16'h0521 : 16'hDEAD;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic        ism;
    logic [3:0]  cnt;
  } exp_t;
  exp_t sbq[$];
  logic [3:0] model_cnt;

  typedef struct {
    logic [15:0] instr;
    logic        ism;
  } vec_t;
  vec_t tbl[8];

  // Commit-side monitor for DUT 1
  int fetch_cyc, en_cnt, mem_cnt;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      en_cnt  = 0;
      mem_cnt = 0;
    end else begin
      chk("busy", busy, state_o != 3'd0);
      chk("dec_en", decoder_en,
          state_o inside {3'd3, 3'd4, 3'd5, 3'd6});
      chk("mem_phase_st", mem_phase,
          state_o == 3'd5);
      if (state_o == 3'd1) begin
        fetch_cyc = cyc;
        en_cnt    = 0;
        mem_cnt   = 0;
      end
      if (bus1.ram_en_b) en_cnt++;
      if (mem_phase) mem_cnt++;
      if (commit) begin
        if (sbq.size() == 0) begin
          chk("commit_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("instr_set", instr_set, e.instr);
          chk("is_mem", is_mem, e.ism);
          chk("count", instr_count, e.cnt);
          chk("latency", cyc - fetch_cyc,
              4 + int'(e.ism));
          chk("en_cycles", en_cnt, 2);
          chk("mem_cycles", mem_cnt, int'(e.ism));
        end
      end
    end
  end

  task automatic wait_state(input logic [2:0] s,
                            input string nm);
    for (int i = 0; i < 40 && state_o !== s; i++)
      @(negedge clk);
    if (state_o !== s) chk(nm, state_o, s);
  endtask

  task automatic run_vec(input logic [15:0] ins,
                         input logic [15:0] a,
                         input logic ism);
    exp_t x;
    wait_state(3'd1, "to_fetch");
    pc       = a;
    exp_addr = a;
    rom_word = ins;
    x.instr  = ins;
    x.ism    = ism;
    x.cnt    = model_cnt;
    sbq.push_back(x);
    model_cnt = model_cnt + 4'd1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; run = 0; pc = 0;
    rom_word = 0; exp_addr = 0;
    reset2 = 1; run2 = 0; pc2 = 0;
    model_cnt = 0;
    tbl[0] = '{16'h0521, 1'b0};
    tbl[1] = '{16'h4102, 1'b1};
    tbl[2] = '{16'h4142, 1'b1};
    tbl[3] = '{16'h4182, 1'b0};
    tbl[4] = '{16'h0000, 1'b0};
    tbl[5] = '{16'h4F4F, 1'b1};
    tbl[6] = '{16'h4010, 1'b0};
    tbl[7] = '{16'hF003, 1'b0};
    repeat (2) @(negedge clk);

    chk("rst_state", state_o, 0);
    chk("rst_commit", commit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ir", instr_set, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_en", bus1.ram_en_b, 0);
    chk("rst_dec", decoder_en, 0);
    chk("rst_ismem", is_mem, 0);
    reset = 0;
    @(negedge clk);

    run = 1;
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i].instr,
              16'h0010 + 16'(i * 4), tbl[i].ism);
      if (i == 7) run = 0;
    end
    wait_state(3'd0, "tbl_idle");
    chk("tbl_cnt", instr_count, 8);
    chk("tbl_sb", sbq.size(), 0);

    run = 1;
    run_vec(16'h0521, 16'h0040, 1'b0);
    run_vec(16'h0521, 16'h0044, 1'b0);
    wait_state(3'd4, "to_exec2");
    run = 0;
    wait_state(3'd0, "stop_idle");
    chk("stop_cnt", instr_count, 10);
    chk("stop_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stop_no_en", bus1.ram_en_b, 0);
    end

    run = 1;
    run_vec(16'h4102, 16'h0050, 1'b1);
    wait_state(3'd5, "to_mem");
    chk("mem_phase", mem_phase, 1);
    reset = 1;
    run = 0;
    sbq.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("mrst_state", state_o, 0);
    chk("mrst_commit", commit, 0);
    chk("mrst_ir", instr_set, 0);
    chk("mrst_cnt", instr_count, 0);
    chk("mrst_dec", decoder_en, 0);
    chk("mrst_ismem", is_mem, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("mrst_idle", state_o, 0);

    run = 1;
    for (int i = 0; i < 17; i++) begin
      run_vec(16'h0521, 16'h0060, 1'b0);
      if (i == 16) run = 0;
    end
    wait_state(3'd0, "wrap_idle");
    chk("wrap_cnt", instr_count, 1);
    chk("wrap_sb", sbq.size(), 0);

    reset2 = 0;
    pc2 = 16'h0010;
    run2 = 1;
    @(negedge clk);
    chk("l2_fetch", state2, 1);
    chk("l2_addr1", bus2.ram_addr_b, 16'h0010);
    chk("l2_en1", bus2.ram_en_b, 1);
    run2 = 0;
    @(negedge clk);
    chk("l2_fwait1", state2, 2);
    chk("l2_en2", bus2.ram_en_b, 1);
    pc2 = 16'h0020;
    @(negedge clk);
    chk("l2_fwait2", state2, 2);
    chk("l2_addr_hold", bus2.ram_addr_b, 16'h0010);
    chk("l2_en3", bus2.ram_en_b, 1);
    @(negedge clk);
    chk("l2_decode", state2, 3);
    chk("l2_ir", instr_set2, 16'h0521);
    chk("l2_dec_en", decoder_en2, 1);
    @(negedge clk);
    chk("l2_no_commit5", commit2, 0);
    @(negedge clk);
    chk("l2_commit6", commit2, 1);
    chk("l2_ismem", is_mem2, 0);
    @(negedge clk);
    chk("l2_idle", state2, 0);
    chk("l2_cnt", instr_count2, 1);
    chk("l2_busy", busy2, 0);
    chk("l2_commit7", commit2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
